// File: rtl/tick_sched_pkg.sv
// Shared sizing and types for the tick scheduler; N_CH and PERIOD_W are fixed here so all files agree.
// pcnt_w() sizes the prescaler counter from its terminal count.
package tick_sched_pkg;

  localparam int N_CH     = 4;
  localparam int PERIOD_W = 16;
  localparam int CH_W     = $clog2(N_CH);

  typedef struct packed {
    logic                en;
    logic [PERIOD_W-1:0] period;
  } ch_cfg_t;

  function automatic int pcnt_w(input int pre_max);
    return (pre_max < 1) ? 1 : $clog2(pre_max + 1);
  endfunction

endpackage

// File: rtl/tick_sched_rr_arbiter.sv
// Round-robin pick of the first set request after last_grant, wrapping; purely combinational.
// No backpressure of its own: the caller decides when the grant is consumed.
module rr_arbiter
  import tick_sched_pkg::*;
#(
  parameter int N = N_CH,
  parameter int W = CH_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] grant,
  output logic         grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!grant_valid && req[idx[W-1:0]]) begin
        grant       = W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Shared prescaler + per-channel period counters + round-robin event port; tick to evt_valid is 2 cycles minimum.
// evt_ch holds while evt_ready=0; a fire on an already pending channel is lost (flagged in ovf when SCHED_OVF_EN).
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int FREG_INPUT = 50_000_000,
  parameter int FREG_TICK  = 1000
) (
  input  logic                clk_in,
  input  logic                nrst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic                cfg_en,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                tick_out,
  output logic                evt_valid,
  output logic [CH_W-1:0]     evt_ch,
  input  logic                evt_ready,
  output logic [N_CH-1:0]     ovf
);

  localparam int                PRE_MAX   = FREG_INPUT / FREG_TICK - 1;
  localparam int                PCNT_W    = pcnt_w(PRE_MAX);
  localparam logic [PCNT_W-1:0] PRE_MAX_V = PCNT_W'(PRE_MAX);

  if (PRE_MAX < 1) begin : g_bad_pre_max
    $error("tick_sched: FREG_INPUT/FREG_TICK must be at least 2");
  end

  logic [PCNT_W-1:0]             pcnt_q, pcnt_d;
  logic                          tick_q, tick_d;
  ch_cfg_t [N_CH-1:0]            cfg_q, cfg_d;
  logic [N_CH-1:0][PERIOD_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]               pend_q, pend_d;
  logic [N_CH-1:0]               fire;
  logic [N_CH-1:0]               granted;
  logic                          evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]               evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]               last_grant_q, last_grant_d;
  logic [CH_W-1:0]               grant;
  logic                          grant_valid;
  logic                          load;

  always_comb begin
    pcnt_d = (pcnt_q == PRE_MAX_V) ? '0 : pcnt_q + 1'b1;
    tick_d = (pcnt_q == PRE_MAX_V);
  end

  // A config write on a channel overrides that channel's tick/fire in the same cycle.
  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    fire  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_we && int'(cfg_ch) == i) begin
        cfg_d[i].en     = cfg_en;
        cfg_d[i].period = cfg_period;
        cnt_d[i]        = '0;
      end else if (tick_q && cfg_q[i].en && cfg_q[i].period != '0) begin
        if (cnt_q[i] >= cfg_q[i].period - 1'b1) begin
          cnt_d[i] = '0;
          fire[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  rr_arbiter #(
    .N(N_CH),
    .W(CH_W)
  ) u_arb (
    .req        (pend_q),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  assign load = !evt_valid_q || evt_ready;

  always_comb begin
    evt_valid_d  = evt_valid_q;
    evt_ch_d     = evt_ch_q;
    last_grant_d = last_grant_q;
    granted      = '0;
    if (load) begin
      evt_valid_d = grant_valid;
      if (grant_valid) begin
        evt_ch_d       = grant;
        last_grant_d   = grant;
        granted[grant] = 1'b1;
      end
    end
  end

  // Set wins over grant-clear, so a fire in the grant cycle re-arms the channel.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_CH; i++) begin
      pend_d[i] = (pend_q[i] && !granted[i]) || fire[i];
      if (cfg_we && int'(cfg_ch) == i) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      pcnt_q       <= '0;
      tick_q       <= 1'b0;
      cfg_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      evt_valid_q  <= 1'b0;
      evt_ch_q     <= '0;
      last_grant_q <= CH_W'(N_CH - 1);
    end else begin
      pcnt_q       <= pcnt_d;
      tick_q       <= tick_d;
      cfg_q        <= cfg_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      evt_valid_q  <= evt_valid_d;
      evt_ch_q     <= evt_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef SCHED_OVF_EN
  logic [N_CH-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (fire & pend_q & ~granted);
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_we && int'(cfg_ch) == i) begin
        ovf_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = '0;
`endif

  assign tick_out  = tick_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched at FREG_INPUT=100, FREG_TICK=10 (base tick every 10 clocks).
// clk_n counts clk_in edges since reset release; outputs are sampled 1ns after each edge.
`timescale 1ns/1ps
module tb_tick_sched;
  import tick_sched_pkg::*;

  logic                clk_in     = 1'b0;
  logic                nrst       = 1'b0;
  logic                cfg_we     = 1'b0;
  logic [CH_W-1:0]     cfg_ch     = '0;
  logic                cfg_en     = 1'b0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic                evt_ready  = 1'b0;
  logic                tick_out;
  logic                evt_valid;
  logic [CH_W-1:0]     evt_ch;
  logic [N_CH-1:0]     ovf;

  int checks   = 0;
  int failures = 0;
  int clk_n    = 0;

`ifdef SCHED_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  tick_sched #(
    .FREG_INPUT(100),
    .FREG_TICK (10)
  ) dut (
    .clk_in    (clk_in),
    .nrst      (nrst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_en    (cfg_en),
    .cfg_period(cfg_period),
    .tick_out  (tick_out),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_ready (evt_ready),
    .ovf       (ovf)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
    clk_n++;
  endtask

  task automatic run_to(input int n);
    while (clk_n < n) cyc();
  endtask

  task automatic wr(input int ch, input bit en, input int per);
    cfg_ch     = CH_W'(ch);
    cfg_en     = en;
    cfg_period = PERIOD_W'(per);
    cfg_we     = 1'b1;
    cyc();
    cfg_we     = 1'b0;
  endtask

  task automatic do_reset();
    nrst      = 1'b0;
    cfg_we    = 1'b0;
    evt_ready = 1'b1;
    cyc();
    cyc();
    nrst  = 1'b1;
    clk_n = 0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    evt_ready = 1'b1;
    cyc();
    checks++; if (tick_out !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick_out); end
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
    checks++; if (evt_ch !== '0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", evt_ch); end
    checks++; if (ovf !== '0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_prescaler();
    logic exp_t;
    do_reset();
    while (clk_n < 30) begin
      cyc();
      exp_t = (clk_n % 10 == 0);
      checks++;
      if (tick_out !== exp_t) begin failures++; $display("FAIL presc_tick clk=%0d got=%b exp=%b", clk_n, tick_out, exp_t); end
      checks++;
      if (evt_valid !== 1'b0 || ovf !== '0) begin
        failures++; $display("FAIL presc_idle clk=%0d valid=%b ovf=%b exp=0/0", clk_n, evt_valid, ovf);
      end
    end
  endtask

  task automatic test_single();
    logic exp_v;
    do_reset();
    wr(0, 1'b1, 3);
    while (clk_n < 100) begin
      cyc();
      exp_v = (clk_n >= 32) && (clk_n % 30 == 2);
      checks++;
      if (evt_valid !== exp_v) begin failures++; $display("FAIL single_valid clk=%0d got=%b exp=%b", clk_n, evt_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (evt_ch !== 2'd0) begin failures++; $display("FAIL single_ch clk=%0d got=%0d exp=0", clk_n, evt_ch); end
      end
    end
  endtask

  task automatic test_round_robin();
    int m;
    logic exp_v;
    logic [CH_W-1:0] exp_c;
    logic [CH_W-1:0] seq [4];
    do_reset();
    for (int c = 0; c < 4; c++) wr(c, 1'b1, 1);
    while (clk_n < 40) begin
      cyc();
      m = clk_n % 10;
      exp_v = (clk_n >= 12) && (m >= 2) && (m <= 5);
      exp_c = CH_W'(m - 2);
      checks++;
      if (evt_valid !== exp_v) begin failures++; $display("FAIL rr_valid clk=%0d got=%b exp=%b", clk_n, evt_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (evt_ch !== exp_c) begin failures++; $display("FAIL rr_ch clk=%0d got=%0d exp=%0d", clk_n, evt_ch, exp_c); end
      end
    end
    // Start with only ch2 granted, then load all channels: order resumes after ch2.
    do_reset();
    wr(2, 1'b1, 1);
    run_to(12);
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd2) begin
      failures++; $display("FAIL rr_start valid=%b ch=%0d exp=1/2", evt_valid, evt_ch);
    end
    wr(0, 1'b1, 1);
    wr(1, 1'b1, 1);
    wr(3, 1'b1, 1);
    run_to(21);
    seq[0] = 2'd3; seq[1] = 2'd0; seq[2] = 2'd1; seq[3] = 2'd2;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== seq[k]) begin
        failures++; $display("FAIL rr_wrap clk=%0d valid=%b ch=%0d exp=1/%0d", clk_n, evt_valid, evt_ch, seq[k]);
      end
    end
    cyc();
    checks++;
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL rr_wrap_end got=%b exp=0", evt_valid); end
  endtask

  task automatic test_backpressure();
    logic [N_CH-1:0] exp_o;
    do_reset();
    evt_ready = 1'b0;
    wr(1, 1'b1, 1);
    run_to(12);
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin failures++; $display("FAIL bp_first valid=%b ch=%0d exp=1/1", evt_valid, evt_ch); end
    run_to(25);
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin failures++; $display("FAIL bp_hold valid=%b ch=%0d exp=1/1", evt_valid, evt_ch); end
    checks++;
    if (ovf !== '0) begin failures++; $display("FAIL bp_no_ovf got=%b exp=0", ovf); end
    run_to(32);
    exp_o = OVF_ON ? 4'b0010 : 4'b0000;
    checks++;
    if (ovf !== exp_o) begin failures++; $display("FAIL bp_ovf got=%b exp=%b", ovf, exp_o); end
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin failures++; $display("FAIL bp_hold2 valid=%b ch=%0d exp=1/1", evt_valid, evt_ch); end
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin failures++; $display("FAIL bp_next valid=%b ch=%0d exp=1/1", evt_valid, evt_ch); end
    cyc();
    checks++;
    if (evt_valid !== 1'b1) begin failures++; $display("FAIL bp_next_hold got=%b exp=1", evt_valid); end
    wr(1, 1'b0, 0);
    checks++;
    if (ovf !== '0) begin failures++; $display("FAIL bp_ovf_clr got=%b exp=0", ovf); end
    evt_ready = 1'b1;
    cyc();
    checks++;
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", evt_valid); end
  endtask

  task automatic test_collision();
    do_reset();
    wr(2, 1'b1, 3);
    run_to(30);
    checks++;
    if (tick_out !== 1'b1) begin failures++; $display("FAIL coll_tick got=%b exp=1", tick_out); end
    wr(2, 1'b1, 3);
    while (clk_n < 61) begin
      cyc();
      checks++;
      if (evt_valid !== 1'b0) begin failures++; $display("FAIL coll_quiet clk=%0d got=%b exp=0", clk_n, evt_valid); end
    end
    cyc();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd2) begin
      failures++; $display("FAIL coll_next clk=%0d valid=%b ch=%0d exp=1/2", clk_n, evt_valid, evt_ch);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_t;
    logic [N_CH-1:0] exp_o;
    do_reset();
    evt_ready = 1'b0;
    wr(0, 1'b1, 1);
    run_to(40);
    exp_o = OVF_ON ? 4'b0001 : 4'b0000;
    checks++;
    if (tick_out !== 1'b1 || evt_valid !== 1'b1 || ovf !== exp_o) begin
      failures++; $display("FAIL mid_pre tick=%b valid=%b ovf=%b exp=1/1/%b", tick_out, evt_valid, ovf, exp_o);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (tick_out !== 1'b0 || evt_valid !== 1'b0 || ovf !== '0 || evt_ch !== '0) begin
      failures++; $display("FAIL mid_async tick=%b valid=%b ovf=%b ch=%0d exp=0/0/0/0", tick_out, evt_valid, ovf, evt_ch);
    end
    cyc();
    nrst      = 1'b1;
    evt_ready = 1'b1;
    clk_n     = 0;
    while (clk_n < 10) begin
      cyc();
      exp_t = (clk_n == 10);
      checks++;
      if (tick_out !== exp_t) begin failures++; $display("FAIL mid_tick clk=%0d got=%b exp=%b", clk_n, tick_out, exp_t); end
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_single();
    test_round_robin();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Multi-channel periodic event scheduler built on one shared prescaler.
- The prescaler divides clk_in down to a base tick. N_CH channels each count base ticks against a programmable period and raise a pending request when the period expires.
- A round-robin arbiter serialises pending requests onto a single valid/ready event port.
- Sits between the system clock domain and slow housekeeping consumers such as LED blink, debounce sampling and watchdog kicks.

Parameters:
- FREG_INPUT, 50_000_000: input clock frequency, Hz.
- FREG_TICK, 1000: base tick frequency, Hz. PRE_MAX = FREG_INPUT/FREG_TICK - 1.
- N_CH, 4: number of channels, 2..16.
- PERIOD_W, 16: channel period width, in ticks.

Ports:
- clk_in, input, 1: system clock.
- nrst, input, 1: reset. One clock; reset is asynchronous and active-low.
- cfg_we, input, 1: config write strobe, one cycle.
- cfg_ch, input, $clog2(N_CH): channel to configure.
- cfg_en, input, 1: channel enable value.
- cfg_period, input, PERIOD_W: channel period in ticks. 0 = never fires.
- tick_out, output, 1: one-cycle base tick strobe.
- evt_valid, output, 1: event available.
- evt_ch, output, $clog2(N_CH): channel of the current event.
- evt_ready, input, 1: consumer accepts the event.
- ovf, output, N_CH: sticky per-channel overflow flags.

Behaviour:
- Reset (async, nrst=0): all of the following clear immediately:
  - prescaler count = 0, tick_out = 0;
  - all en, period and count = 0;
  - all pend = 0, evt_valid = 0, evt_ch = 0, ovf = 0;
  - last_grant = N_CH-1, so ch0 has first priority.
  - Reset mid-handshake drops evt_valid without completion.
- Prescaler:
  - pcnt counts 0..PRE_MAX.
  - When pcnt == PRE_MAX, pcnt wraps to 0 and tick_out=1 in the next cycle only.
  - The first tick_out occurs PRE_MAX+1 clocks after reset release.
  - Channel logic uses registered tick_out as its tick strobe.
- Channel i, on tick with en=1 and period!=0:
  - If count >= period-1: count <= 0 and fire. Fire sets pend[i] in the next cycle.
  - Otherwise: count <= count+1.
  - Disabled or period==0 channels hold count and never fire.
- Config write (cfg_we=1):
  - Loads en and period for cfg_ch, and clears its count and pend.
  - Clears ovf[cfg_ch] when SCHED_OVF_EN is defined.
  - Write beats a same-cycle tick or fire on that channel: no pend is set and count = 0.
  - Other channels are unaffected.
- Output stage:
  - The register slot loads whenever evt_valid=0, or evt_valid=1 and evt_ready=1.
  - On load, the arbiter grants the first set pend bit searching from last_grant+1 and wrapping.
  - Granting sets evt_valid=1, evt_ch=grant, last_grant=grant, and clears pend[grant].
  - With no pend set, evt_valid goes 0.
  - While evt_valid=1 and evt_ready=0, evt_ch is held stable.
- Latency: tick_out high in cycle T → pend set in T+1 → evt_valid in T+2 at the earliest.
- Simultaneous events:
  - A grant-clear and a new fire on the same channel in one cycle leave pend=1, with no overflow.
  - A fire while pend already = 1 and not granted that cycle counts as an overflow: the event is lost and pend stays 1.
- Widths:
  - count is PERIOD_W bits.
  - The prescaler counter is $clog2(PRE_MAX+1) bits.
  - PRE_MAX < 1 is an elaboration error.

Optional Feature:
- Macro SCHED_OVF_EN.
- Defined: ovf[i] sets on an overflow of channel i and stays set until a cfg_we to channel i or reset.
- Undefined: ovf is tied to '0 and no overflow logic is synthesised. Event-loss behaviour is otherwise identical.

Decomposition:
- Package tick_sched_pkg holds:
  - typedef ch_cfg_t (struct: en, period);
  - localparam helper for the prescaler-count width;
  - CH_W = $clog2(N_CH).
- One sub-module, rr_arbiter: N_CH request vector plus last_grant in; combinational grant index and grant_valid out.

Test Plan:
- Prescaler after reset, FREG_INPUT=100, FREG_TICK=10: tick_out pulses at clock 10, 20, 30…, exactly one cycle wide; all other outputs stay 0.
- Single channel, ch0 period=3 enabled, evt_ready=1: evt_valid with evt_ch=0 appears 2 cycles after every 3rd tick, i.e. every 30 clocks, each valid for one cycle.
- Round-robin, ch0..ch3 period=1 all enabled, ready=1: after each tick evt_ch = 0,1,2,3 on 4 consecutive cycles. Under constant load with a start at ch2 pending only, the next tick order is 3,0,1,2.
- Backpressure, ch1 period=1, ready=0:
  - evt_valid=1 and evt_ch=1 held across ticks.
  - The second tick sets ovf[1]=1 (macro defined) or leaves ovf=0 (undefined).
  - ready=1 for one cycle then 0: the held event completes and a single further event (pend) follows. A cfg_we to ch1 clears ovf[1].
- Write-vs-fire collision: cfg_we to ch2 in the same cycle as ch2's firing tick → no ch2 event; the next ch2 event comes a full period later.
- Reset mid-operation: nrst low while evt_valid=1 → evt_valid, tick_out and ovf read 0 before the next clk_in edge. After release, the first tick follows at clock 10.
